// File: rtl/ascii_dec_tx.sv
// Prints one unsigned FIFO word as decimal characters over a UART transmitter.
// The binary-to-BCD conversion is sequential double-dabble: one input bit per cycle.
module ascii_dec_tx #(
    parameter int         DATA_W      = 8,
    parameter int         NDIG        = 3,
    parameter bit         ASCII_EN    = 1'b1,
    parameter bit         LZ_SUPPRESS = 1'b1,
    parameter bit         TERM_EN     = 1'b1,
    parameter logic [7:0] TERM_CHAR   = 8'h0A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [DATA_W-1:0] value,
    input  logic              tx_done_tick,
    output logic [7:0]        d_in,
    output logic              tx_start,
    output logic              rd,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * NDIG;

    // Handshakes: a word is available while rx_empty=0 and is consumed by a
    // one-cycle rd pulse; each byte is offered by a one-cycle tx_start with d_in
    // held until the transmitter answers with a rising tx_done_tick.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        SEND  = 3'd2,
        WAIT  = 3'd3,
        TERM  = 3'd4,
        TWAIT = 3'd5,
        POP   = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] shreg;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_step;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_dec;
    logic [IDX_W-1:0]  idx_first;
    logic              after_pop;
    logic              tick_d;
    logic              tick_rise;
    logic              conv_last;

    function automatic logic [7:0] to_byte(input logic [3:0] digit);
        return ASCII_EN ? {4'h3, digit} : {4'h0, digit};
    endfunction

    // A completion held high for several cycles counts once: only its rising edge is used.
    assign tick_rise = tx_done_tick & ~tick_d;
    assign conv_last = (cnt == CNT_W'(DATA_W - 1));
    assign idx_dec   = idx - 1'b1;
    assign dbg_state = state;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = BCD_W'({bcd_adj, shreg[DATA_W-1]});
    end

    // First digit to print, taken from the BCD value produced by the final conversion step.
    always_comb begin
        idx_first = IDX_W'(NDIG - 1);
        if (LZ_SUPPRESS) begin
            idx_first = '0;
            for (int i = 1; i < NDIG; i++) begin
                if (bcd_step[4*i +: 4] != 4'd0) begin
                    idx_first = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        rd         = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!rx_empty && !after_pop) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_last) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (tick_rise) begin
                    if (idx != '0) begin
                        state_next = SEND;
                    end else if (TERM_EN) begin
                        state_next = TERM;
                    end else begin
                        state_next = POP;
                    end
                end
            end
            TERM: begin
                tx_start   = 1'b1;
                state_next = TWAIT;
            end
            TWAIT: begin
                if (tick_rise) begin
                    state_next = POP;
                end
            end
            POP: begin
                rd         = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bcd       <= '0;
            cnt       <= '0;
            idx       <= '0;
            d_in      <= 8'h00;
            after_pop <= 1'b0;
            tick_d    <= 1'b0;
        end else begin
            tick_d    <= tx_done_tick;
            after_pop <= (state == POP);
            case (state)
                IDLE: begin
                    if (state_next == CONV) begin
                        shreg <= value;
                        bcd   <= '0;
                        cnt   <= '0;
                    end
                end
                CONV: begin
                    bcd   <= bcd_step;
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                    if (conv_last) begin
                        idx  <= idx_first;
                        d_in <= to_byte(bcd_step[{idx_first, 2'b00} +: 4]);
                    end
                end
                WAIT: begin
                    if (tick_rise) begin
                        if (idx != '0) begin
                            idx  <= idx_dec;
                            d_in <= to_byte(bcd[{idx_dec, 2'b00} +: 4]);
                        end else if (TERM_EN) begin
                            d_in <= TERM_CHAR;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_dec_tx.sv
// Bench for ascii_dec_tx: a default instance with a randomized FIFO/UART model and a
// 16-bit raw-BCD instance, both checked against decimal-arithmetic reference models.
module tb_ascii_dec_tx;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        reset, rx_empty, tx_done_tick, tx_start, rd, busy;
    logic [7:0]  value, d_in;
    logic [2:0]  dbg_state;
    logic        reset_w, rx_empty_w, tick_w, tx_start_w, rd_w, busy_w;
    logic [15:0] value_w;
    logic [7:0]  d_in_w;
    logic [2:0]  dbg_state_w;

    always #5 clk = ~clk;

    ascii_dec_tx u_dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .value(value),
        .tx_done_tick(tx_done_tick), .d_in(d_in), .tx_start(tx_start),
        .rd(rd), .busy(busy), .dbg_state(dbg_state)
    );

    ascii_dec_tx #(
        .DATA_W(16), .NDIG(5), .ASCII_EN(1'b0), .LZ_SUPPRESS(1'b0), .TERM_EN(1'b0)
    ) u_wide (
        .clk(clk), .reset(reset_w), .rx_empty(rx_empty_w), .value(value_w),
        .tx_done_tick(tick_w), .d_in(d_in_w), .tx_start(tx_start_w),
        .rd(rd_w), .busy(busy_w), .dbg_state(dbg_state_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         nexp_q[$];
    int         fifo_q[$];
    logic [7:0] exp_w_q[$];
    int         fifo_w_q[$];
    int         words = 0;
    int         rd_cnt = 0;
    int         rd_w_cnt = 0;

    // UART / FIFO model knobs, set by the stimulus process
    int d_fixed = 10;
    bit hold_en = 1'b0;
    bit spur_en = 1'b0;

    bit         tx_busy = 1'b0;
    int         tx_cnt = 0;
    int         tick_left = 0;
    logic [7:0] cap = 8'h00;
    int         busy_run = 0;
    int         char_cycles = 0;
    int         starts_word = 0;
    bit         gap_arm = 1'b0;
    bit         gap_valid = 1'b0;
    int         gap = 0;
    int         w_cnt = 0;

    task automatic model_push(input int v);
        int d[3];
        int top;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = v / 100;
        top = 0;
        for (int i = 2; i >= 1; i--) begin
            if (d[i] != 0 && top == 0) top = i;
        end
        for (int i = top; i >= 0; i--) exp_q.push_back(8'(8'h30 + d[i]));
        exp_q.push_back(8'h0A);
        nexp_q.push_back(top + 2);
    endtask

    task automatic push_word(input int v);
        fifo_q.push_back(v);
        model_push(v);
        words++;
    endtask

    task automatic push_wide(input int v);
        int p;
        fifo_w_q.push_back(v);
        p = 10000;
        for (int i = 4; i >= 0; i--) begin
            exp_w_q.push_back(8'((v / p) % 10));
            p = p / 10;
        end
    endtask

    // ---------------- default instance: FIFO + UART model + monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            tx_busy = 1'b0; tick_left = 0; tx_done_tick = 1'b0;
            busy_run = 0; char_cycles = 0; starts_word = 0; gap_arm = 1'b0;
        end else begin
            if (gap_arm) begin
                if (busy) begin
                    if (gap_valid) check_eq("idle_gap", gap, 2);
                    gap_arm = 1'b0;
                end else begin
                    gap++;
                end
            end
            if (busy) busy_run++;
            if (tx_start) begin
                check_eq("start_while_pending", tx_busy, 0);
                if (exp_q.size() == 0) check_eq("byte_expected", 0, 1);
                else check_eq("byte", d_in, exp_q.pop_front());
                cap = d_in;
                tx_busy = 1'b1;
                starts_word++;
                if (d_fixed != 0) tx_cnt = d_fixed;
                else if (hold_en) tx_cnt = $urandom_range(4, 12);
                else tx_cnt = $urandom_range(1, 12);
                char_cycles += 1 + tx_cnt;
            end else if (tx_busy) begin
                check_eq("d_in_stable", d_in, cap);
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_busy = 1'b0;
                    tick_left = (hold_en && $urandom_range(0, 1) == 1) ? 3 : 1;
                end
            end else if (spur_en && busy && tick_left == 0 && $urandom_range(0, 3) == 0) begin
                tick_left = 1;
            end
            tx_done_tick = (tick_left > 0);
            if (tick_left > 0) tick_left--;
            if (rd) begin
                rd_cnt++;
                check_eq("word_cycles", busy_run, DW + 1 + char_cycles);
                if (nexp_q.size() > 0) check_eq("starts_per_word", starts_word, nexp_q.pop_front());
                if (fifo_q.size() > 0) fifo_q.delete(0);
                else check_eq("rd_on_empty", 1, 0);
                busy_run = 0; char_cycles = 0; starts_word = 0;
                gap_arm = 1'b1; gap = 0; gap_valid = (fifo_q.size() > 0);
            end
        end
        rx_empty = (fifo_q.size() == 0);
        value    = rx_empty ? 8'h00 : 8'(fifo_q[0]);
    end

    // ---------------- wide instance: fixed 3-cycle UART ----------------
    always @(negedge clk) begin
        if (reset_w) begin
            w_cnt = 0; tick_w = 1'b0;
        end else begin
            tick_w = 1'b0;
            if (w_cnt > 0) begin
                w_cnt--;
                if (w_cnt == 0) tick_w = 1'b1;
            end
            if (tx_start_w) begin
                if (exp_w_q.size() == 0) check_eq("wide_byte_expected", 0, 1);
                else check_eq("wide_byte", d_in_w, exp_w_q.pop_front());
                w_cnt = 3;
            end
            if (rd_w) begin
                rd_w_cnt++;
                if (fifo_w_q.size() > 0) fifo_w_q.delete(0);
                else check_eq("wide_rd_on_empty", 1, 0);
            end
        end
        rx_empty_w = (fifo_w_q.size() == 0);
        value_w    = rx_empty_w ? 16'h0000 : 16'(fifo_w_q[0]);
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || fifo_w_q.size() != 0 || busy || busy_w || tx_busy)
               && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) check_eq("drain_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int boundary[6];
        boundary[0] = 0; boundary[1] = 9; boundary[2] = 10;
        boundary[3] = 99; boundary[4] = 100; boundary[5] = 255;
        reset = 1'b1; reset_w = 1'b1;
        rx_empty = 1'b1; value = 8'h00; tx_done_tick = 1'b0;
        rx_empty_w = 1'b1; value_w = 16'h0000; tick_w = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_rd", rd, 0);
        check_eq("rst_d_in", d_in, 0);
        check_eq("rst_state", dbg_state, 0);
        check_eq("rst_wide_busy", busy_w, 0);
        reset = 1'b0; reset_w = 1'b0;

        // idle with an empty FIFO: nothing moves
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("idle_hold", {busy, tx_start, rd}, 0);
        end

        push_wide(65535);
        push_wide(0);
        for (int i = 0; i < 4; i++) push_wide($urandom_range(0, 65535));

        push_word(0);
        wait_drain(2000);
        check_eq("rd_count_zero", rd_cnt, 1);
        push_word(255);
        wait_drain(2000);
        check_eq("rd_count_255", rd_cnt, 2);
        push_word(100);
        push_word(7);
        wait_drain(3000);
        check_eq("rd_count_b2b", rd_cnt, 4);
        check_eq("wide_rd_count", rd_w_cnt, 6);

        // reset one cycle after the first tx_start aborts the word without a pop
        push_word(42);
        n = 0;
        while (!tx_start && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("abort_saw_start", tx_start, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_tx_start", tx_start, 0);
        check_eq("abort_d_in", d_in, 0);
        check_eq("abort_rd_count", rd_cnt, 4);
        exp_q.delete();
        nexp_q.delete();
        model_push(42);
        wait_drain(2000);
        check_eq("rd_count_resend", rd_cnt, 5);

        // randomized traffic with variable UART delay, held and spurious ticks
        d_fixed = 0; hold_en = 1'b1; spur_en = 1'b1;
        for (int i = 0; i < 36; i++) begin
            push_word((i < 6) ? boundary[i] : int'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) push_word($urandom_range(0, 255));
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #1;
        end
        wait_drain(40000);
        check_eq("rd_count_total", rd_cnt, words);
        check_eq("wide_exp_drained", exp_w_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii_dec_tx.md
ASCII_DEC_TX -- requirements
Module: ascii_dec_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the unsigned binary value to print.
REQ-002 SHALL have parameter NDIG, default 3: decimal digit count, legal only when 10^NDIG > 2^DATA_W-1.
REQ-003 SHALL have parameter ASCII_EN, default 1: 1 sends ASCII '0'..'9' (8'h30+d), 0 sends raw BCD 8'h00..8'h09.
REQ-004 SHALL have parameter LZ_SUPPRESS, default 1: 1 omits leading zeros, 0 sends all NDIG digits.
REQ-005 SHALL have parameter TERM_EN, default 1: 1 sends TERM_CHAR after the last digit.
REQ-006 SHALL have parameter TERM_CHAR, default 8'h0A: terminator byte.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port rx_empty, input, 1: source FIFO empty flag; 0 means value is valid.
REQ-010 SHALL have port value, input, DATA_W: FIFO head word.
REQ-011 SHALL have port tx_done_tick, input, 1: UART TX one-cycle completion pulse.
REQ-012 SHALL have port d_in, output, 8: byte presented to UART TX.
REQ-013 SHALL have port tx_start, output, 1: one-cycle UART TX start pulse.
REQ-014 SHALL have port rd, output, 1: one-cycle FIFO pop pulse.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, CONV, SEND, WAIT, TERM, TWAIT and POP, all registered.
REQ-017 In IDLE with rx_empty=0, SHALL latch value and enter CONV on the next edge.
REQ-018 In IDLE with rx_empty=1, SHALL hold all state and outputs.
REQ-019 CONV SHALL run sequential double-dabble (shift-add-3), one bit per cycle, for exactly DATA_W cycles, then enter SEND.
REQ-020 SHALL use no divider or modulo operator.
REQ-021 SHALL hold NDIG 4-bit BCD digits; the digit index counts from NDIG-1 (MSD) down to 0.
REQ-022 With LZ_SUPPRESS=1, SHALL skip leading zero digits without spending SEND or WAIT cycles on them.
REQ-023 With LZ_SUPPRESS=1, digit 0 SHALL always be sent, so a value of 0 prints one '0'.
REQ-024 On entering SEND, SHALL drive d_in with the digit byte, assert tx_start for exactly one cycle, then enter WAIT.
REQ-025 d_in SHALL stay stable from the SEND cycle until the matching tx_done_tick.
REQ-026 In WAIT on tx_done_tick, SHALL go to SEND if digits remain, else to TERM when TERM_EN=1, else to POP.
REQ-027 TERM SHALL drive d_in=TERM_CHAR, pulse tx_start for one cycle and enter TWAIT; TWAIT on tx_done_tick SHALL enter POP.
REQ-028 POP SHALL assert rd for exactly one cycle and return to IDLE.
REQ-029 IDLE SHALL ignore rx_empty in the cycle right after POP, so the FIFO can update before the next fetch.
REQ-030 SHALL ignore tx_done_tick in any state other than WAIT or TWAIT.
REQ-031 SHALL never assert tx_start while waiting for an outstanding tx_done_tick.
REQ-032 Changes to value or rx_empty after the IDLE latch SHALL not affect the word being printed.
REQ-033 Minimum cycles per word, with n sent characters and D the delay from tx_start to tx_done_tick: 1 + DATA_W + n*(1+D) + 1.

Reset
REQ-034 reset=1 at a rising edge SHALL force IDLE and set d_in=0, tx_start=0, rd=0, busy=0, and clear the digit, latch and index registers.
REQ-035 reset SHALL take priority over every other input.
REQ-036 A reset taken mid-word SHALL abort the word with no rd pulse, so the word stays in the FIFO.

Verification
REQ-037 Default params, value=8'd0, TX model D=10 -> bytes 8'h30, 8'h0A; one rd pulse.
REQ-038 Default params, value=8'd255 -> bytes 8'h32, 8'h35, 8'h35, 8'h0A; tx_start pulses=4; rd pulses=1.
REQ-039 Default params, value=8'd100 then 8'd7 back-to-back, rx_empty=0 throughout -> bytes 31,30,30,0A then 37,0A (hex); one rd per word; an idle gap after each rd.
REQ-040 DATA_W=16, NDIG=5, LZ_SUPPRESS=0, ASCII_EN=0, TERM_EN=0, value=16'd65535 -> bytes 06,05,05,03,05 (hex); no terminator.
REQ-041 value=8'd42, reset=1 for one cycle after the first tx_start -> busy=0 the next cycle; no rd; the word is re-sent as 34,32,0A (hex) once reset=0.
REQ-042 Spurious tx_done_tick during CONV, plus tx_done_tick held 3 cycles in WAIT -> the extra ticks cause no skipped character and no double tx_start.
